psram_cmd_scheduler: RTL and testbench
======================================

Name: psram_cmd_scheduler

Overview:
- Shares the single PSRAM controller command port between two burst-bus requesters: m1 is the framebuffer and m2 is the debug/burst writer.
- Replaces the free-running busy flag and the simple arbiter with three functions: grant arbitration, enforced Tcmd spacing, and tagged read-return routing.
- Read commands may then issue while the previous read's data is still returning.
- Sits between the requesters and the PSRAM controller, in the controller's clk domain.

Parameters:
- CMD_GAP, 14, minimum cycles from one mem_cmd_en to the next (IPUG 943 Tcmd for burst 16).
- RD_BEATS, 4, rd_data_valid beats per read burst (64-bit beats).
- RD_TIMEOUT, 32, cycles a head read may wait for its first beat before it is abandoned.
- STARVE_LIMIT, 4, consecutive m1 grants allowed while m2_req is pending.
- RQ_DEPTH, 2, depth of the outstanding-read owner queue.

Ports:
- clk  in  1  controller clk_out
- resetn  in  1  asynchronous, active-low reset
- calib  in  1  controller init_calib; no grants while low
- m1_req, m2_req  in  1  requester wants the port (level)
- m1_ready, m2_ready  out  1  grant; at most one high
- m1_cmd_en, m2_cmd_en  in  1  command strobe; valid only while own ready is high
- m1_cmd, m2_cmd  in  1  1 = write, 0 = read
- m1_addr, m2_addr  in  21  burst address
- m1_wr_data, m2_wr_data  in  64  write data
- m1_data_mask, m2_data_mask  in  8  byte mask
- m1_rd_data, m2_rd_data  out  64  routed read data
- m1_rd_data_valid, m2_rd_data_valid  out  1  routed beat strobe
- mem_cmd_en, mem_cmd  out  1  to controller
- mem_addr  out  21
- mem_wr_data  out  64
- mem_data_mask  out  8
- mem_rd_data  in  64  from controller
- mem_rd_data_valid  in  1  from controller
- rd_timeout  out  1  sticky error flag

Behaviour:
- Reset values (asynchronous, resetn low):
  - state = IDLE, owner = m1, starvation counter = 0, read queue empty.
  - All ready, cmd_en and rd_data_valid outputs = 0; rd_timeout = 0.
- FSM states:
  - IDLE: if calib and any request, go to GRANT the next cycle.
    - Select m1 if m1_req, unless starve_cnt == STARVE_LIMIT and m2_req; then select m2.
    - Register the selection as owner.
  - GRANT: owner's ready = 1.
    - If the owner's cmd_en is high, go to GAP. mem_cmd_en, mem_cmd and mem_addr are combinational pass-through of the owner's signals in this cycle (zero latency).
    - If the owner's req drops without cmd_en, go back to IDLE.
    - Ready is forced low in GRANT while the command is a read and the queue is full. This keeps the queue from overflowing.
  - GAP: count CMD_GAP-1 cycles, then go to IDLE.
    - CMD_GAP = 14 gives mem_cmd_en pulses at least 14 cycles apart.
- Starvation counter:
  - Increments on each m1 issue while m2_req is high.
  - Clears on an m2 issue or when m2_req is low.
- Write data:
  - mem_wr_data and mem_data_mask are combinational mux of owner's signals at all times.
  - The owner is stable from GRANT through GAP, covering all write beats.
- Read queue:
  - A read issue pushes the owner id.
  - Each mem_rd_data_valid beat is routed to the head's owner: its rd_data = mem_rd_data and its valid = 1, same cycle. The other master's valid = 0, and its rd_data holds the last value.
  - After RD_BEATS beats the head is popped.
  - A beat arriving with the queue empty is dropped.
  - A push and a pop in the same cycle are both honoured.
- Timeout:
  - A head entry with no beat for RD_TIMEOUT cycles is popped and sets rd_timeout.
  - rd_timeout stays high until reset.
- calib falling: no new grant; a GRANT state with no cmd_en returns to IDLE; GAP completes.
- Reset mid-operation: the queue is flushed; beats arriving later are dropped.

Optional Feature:
- Macro: PSRAM_SCHED_STATS_EN.
- Defined:
  - Adds outputs m1_issue_cnt[15:0] and m2_issue_cnt[15:0], incremented per issued command and saturating at 16'hFFFF.
  - Adds max_rd_latency[7:0]: the largest count from read issue to first beat seen so far, saturating at 255.
  - All three reset to 0.
- Undefined: these ports are absent and no counter logic is built.

Test Plan:
- calib = 0 with m1_req = 1 for 50 cycles -> m1_ready stays 0 and mem_cmd_en is never asserted. Then calib = 1 -> m1_ready rises within 2 cycles.
- m1 issues back-to-back reads -> mem_cmd_en pulses exactly 14 cycles apart. The 4 beats of each read appear on m1_rd_data_valid only; m2_rd_data_valid stays 0.
- m1 and m2 requesting continuously -> grant order m1, m1, m1, m1, m2, m1... (STARVE_LIMIT = 4).
- m1 read, then an m2 read issued 14 cycles later while m1's beats are still returning -> first 4 beats go to m1 and the next 4 to m2. No beat is lost or misrouted.
- Read with no rd_data_valid returned -> head popped and rd_timeout = 1 after 32 cycles. A subsequent read then routes normally.
- resetn pulsed low while a read is outstanding -> all outputs return to 0 asynchronously and the late beats are not forwarded to any master. With PSRAM_SCHED_STATS_EN, 3 m2 writes -> m2_issue_cnt = 3.

Source files
------------

// File: rtl/psram_cmd_scheduler.sv
// psram_cmd_scheduler: shares one PSRAM controller command port between the
// framebuffer (m1) and the debug/burst writer (m2). Provides grant arbitration
// with a starvation guard, enforced command spacing, and tagged routing of
// read-return beats so reads can be pipelined.
// Optional build macro PSRAM_SCHED_STATS_EN adds issue counters and a
// maximum read-latency tracker.
module psram_cmd_scheduler #(
    parameter int unsigned CMD_GAP      = 14,  // must be >= 3
    parameter int unsigned RD_BEATS     = 4,
    parameter int unsigned RD_TIMEOUT   = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned RQ_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        calib,
    input  logic        m1_req,
    input  logic        m2_req,
    output logic        m1_ready,
    output logic        m2_ready,
    input  logic        m1_cmd_en,
    input  logic        m2_cmd_en,
    input  logic        m1_cmd,
    input  logic        m2_cmd,
    input  logic [20:0] m1_addr,
    input  logic [20:0] m2_addr,
    input  logic [63:0] m1_wr_data,
    input  logic [63:0] m2_wr_data,
    input  logic [7:0]  m1_data_mask,
    input  logic [7:0]  m2_data_mask,
    output logic [63:0] m1_rd_data,
    output logic [63:0] m2_rd_data,
    output logic        m1_rd_data_valid,
    output logic        m2_rd_data_valid,
    output logic        mem_cmd_en,
    output logic        mem_cmd,
    output logic [20:0] mem_addr,
    output logic [63:0] mem_wr_data,
    output logic [7:0]  mem_data_mask,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_data_valid,
    output logic        rd_timeout
`ifdef PSRAM_SCHED_STATS_EN
    ,
    output logic [15:0] m1_issue_cnt,
    output logic [15:0] m2_issue_cnt,
    output logic [7:0]  max_rd_latency
`endif
);

    localparam int unsigned GAP_W  = (CMD_GAP > 2) ? $clog2(CMD_GAP) : 1;
    localparam int unsigned BEAT_W = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
    localparam int unsigned TMO_W  = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam int unsigned SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned PTR_W  = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RQ_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;   // 0 = m1, 1 = m2
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [SC_W-1:0]    starve_q;

    logic               own_req, own_cmd_en, own_cmd;
    logic               sel_m2;
    logic               grant_ok;
    logic               issue;

    logic               rq_mem [RQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   rq_cnt;
    logic               rq_full, rq_empty;
    logic               rq_push, rq_pop;
    logic               head_owner;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               beat, last_beat, tmo_hit;
    logic [63:0]        m1_hold, m2_hold;

    // Owner-selected request side signals
    always_comb begin
        own_req       = owner_q ? m2_req       : m1_req;
        own_cmd_en    = owner_q ? m2_cmd_en    : m1_cmd_en;
        own_cmd       = owner_q ? m2_cmd       : m1_cmd;
        mem_addr      = owner_q ? m2_addr      : m1_addr;
        mem_wr_data   = owner_q ? m2_wr_data   : m1_wr_data;
        mem_data_mask = owner_q ? m2_data_mask : m1_data_mask;
    end

    assign rq_full  = (rq_cnt == CNT_W'(RQ_DEPTH));
    assign rq_empty = (rq_cnt == '0);

    // Grant is withheld for a read while the owner queue cannot accept it
    assign grant_ok   = (state_q == ST_GRANT) && !(!own_cmd && rq_full);
    assign issue      = grant_ok && own_cmd_en;
    assign m1_ready   = grant_ok && !owner_q;
    assign m2_ready   = grant_ok && owner_q;
    assign mem_cmd_en = issue;
    assign mem_cmd    = own_cmd;

    assign sel_m2 = !m1_req || (m2_req && (starve_q == SC_W'(STARVE_LIMIT)));

    // Arbitration FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Arbitration FSM next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (calib && (m1_req || m2_req)) begin
                    state_d = ST_GRANT;
                    owner_d = sel_m2;
                end
            end
            ST_GRANT: begin
                if (issue)
                    state_d = ST_GAP;
                else if (!own_req || !calib)
                    state_d = ST_IDLE;
            end
            ST_GAP: begin
                // Issue cycle, GAP cycles and the IDLE re-arbitration cycle
                // together give exactly CMD_GAP cycles between issues.
                if (gap_cnt_q == GAP_W'(CMD_GAP - 3))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command spacing counter, restarted at every issue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            gap_cnt_q <= '0;
        else if (issue)
            gap_cnt_q <= '0;
        else if (state_q == ST_GAP)
            gap_cnt_q <= gap_cnt_q + 1'b1;
    end

    // Consecutive m1 issues while m2 waits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve_q <= '0;
        else if (!m2_req)
            starve_q <= '0;
        else if (issue && owner_q)
            starve_q <= '0;
        else if (issue && !owner_q && (starve_q != SC_W'(STARVE_LIMIT)))
            starve_q <= starve_q + 1'b1;
    end

    assign head_owner = rq_mem[rd_ptr];
    assign rq_push    = issue && !own_cmd;
    assign beat       = mem_rd_data_valid && !rq_empty;
    assign last_beat  = beat && (beat_cnt == BEAT_W'(RD_BEATS - 1));
    assign tmo_hit    = !rq_empty && !mem_rd_data_valid &&
                        (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));
    assign rq_pop     = last_beat || tmo_hit;

    // Outstanding-read owner queue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < RQ_DEPTH; i++)
                rq_mem[i] <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rq_cnt <= '0;
        end else begin
            if (rq_push) begin
                rq_mem[wr_ptr] <= owner_q;
                wr_ptr <= (wr_ptr == PTR_W'(RQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rq_pop)
                rd_ptr <= (rd_ptr == PTR_W'(RQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({rq_push, rq_pop})
                2'b10:   rq_cnt <= rq_cnt + 1'b1;
                2'b01:   rq_cnt <= rq_cnt - 1'b1;
                default: rq_cnt <= rq_cnt;
            endcase
        end
    end

    // Beat count within the head burst and head wait timer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (rq_pop)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + 1'b1;

            if (rq_empty || beat || rq_pop)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rd_timeout <= 1'b0;
        else if (tmo_hit)
            rd_timeout <= 1'b1;
    end

    assign m1_rd_data_valid = beat && !head_owner;
    assign m2_rd_data_valid = beat && head_owner;
    assign m1_rd_data       = m1_rd_data_valid ? mem_rd_data : m1_hold;
    assign m2_rd_data       = m2_rd_data_valid ? mem_rd_data : m2_hold;

    // Last routed beat per master, presented while that master is not addressed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m1_hold <= '0;
            m2_hold <= '0;
        end else begin
            if (m1_rd_data_valid)
                m1_hold <= mem_rd_data;
            if (m2_rd_data_valid)
                m2_hold <= mem_rd_data;
        end
    end

`ifdef PSRAM_SCHED_STATS_EN
    logic [7:0] rq_lat [RQ_DEPTH];

    // Saturating per-master issue counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m1_issue_cnt <= '0;
            m2_issue_cnt <= '0;
        end else if (issue) begin
            if (!owner_q && (m1_issue_cnt != '1))
                m1_issue_cnt <= m1_issue_cnt + 1'b1;
            if (owner_q && (m2_issue_cnt != '1))
                m2_issue_cnt <= m2_issue_cnt + 1'b1;
        end
    end

    // Per-slot age since issue; the head's age is sampled at its first beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < RQ_DEPTH; i++)
                rq_lat[i] <= '0;
            max_rd_latency <= '0;
        end else begin
            for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
                if (rq_push && (wr_ptr == PTR_W'(i)))
                    rq_lat[i] <= 8'd1;
                else if (rq_lat[i] != '1)
                    rq_lat[i] <= rq_lat[i] + 1'b1;
            end
            if (beat && (beat_cnt == '0) && (rq_lat[rd_ptr] > max_rd_latency))
                max_rd_latency <= rq_lat[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// tb_psram_cmd_scheduler: directed stimulus with scoreboard queues for issued
// commands and routed read beats, checked by independent monitor processes.
module tb_psram_cmd_scheduler;

    localparam int CMD_GAP = 14;

    logic        clk = 1'b0;
    logic        resetn, calib;
    logic        m1_req, m2_req, m1_ready, m2_ready;
    logic        m1_cmd_en, m2_cmd_en, m1_cmd, m2_cmd;
    logic [20:0] m1_addr, m2_addr;
    logic [63:0] m1_wr_data, m2_wr_data;
    logic [7:0]  m1_data_mask, m2_data_mask;
    logic [63:0] m1_rd_data, m2_rd_data;
    logic        m1_rd_data_valid, m2_rd_data_valid;
    logic        mem_cmd_en, mem_cmd;
    logic [20:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_data_mask;
    logic [63:0] mem_rd_data;
    logic        mem_rd_data_valid;
    logic        rd_timeout;
`ifdef PSRAM_SCHED_STATS_EN
    logic [15:0] m1_issue_cnt, m2_issue_cnt;
    logic [7:0]  max_rd_latency;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [22:0] exp_cmd_q [$];
    logic [64:0] exp_beat_q [$];
    int          iss_t [$];
    logic [63:0] last_m1 = '0;
    logic [63:0] last_m2 = '0;

    psram_cmd_scheduler #(
        .CMD_GAP(14), .RD_BEATS(4), .RD_TIMEOUT(32), .STARVE_LIMIT(4), .RQ_DEPTH(2)
    ) dut (
        .clk(clk), .resetn(resetn), .calib(calib),
        .m1_req(m1_req), .m2_req(m2_req),
        .m1_ready(m1_ready), .m2_ready(m2_ready),
        .m1_cmd_en(m1_cmd_en), .m2_cmd_en(m2_cmd_en),
        .m1_cmd(m1_cmd), .m2_cmd(m2_cmd),
        .m1_addr(m1_addr), .m2_addr(m2_addr),
        .m1_wr_data(m1_wr_data), .m2_wr_data(m2_wr_data),
        .m1_data_mask(m1_data_mask), .m2_data_mask(m2_data_mask),
        .m1_rd_data(m1_rd_data), .m2_rd_data(m2_rd_data),
        .m1_rd_data_valid(m1_rd_data_valid), .m2_rd_data_valid(m2_rd_data_valid),
        .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .rd_timeout(rd_timeout)
`ifdef PSRAM_SCHED_STATS_EN
        ,
        .m1_issue_cnt(m1_issue_cnt), .m2_issue_cnt(m2_issue_cnt),
        .max_rd_latency(max_rd_latency)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] wd(input logic [20:0] a);
        return {11'h5A5, a, 11'h3C3, a};
    endfunction

    function automatic logic [22:0] ce(input int m, input logic c, input logic [20:0] a);
        return {(m == 2), c, a};
    endfunction

    function automatic logic [64:0] be(input int m, input logic [63:0] d);
        return {(m == 2), d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester model: holds req and cmd_en until its grant is seen
    task automatic issue(input int m, input logic c, input logic [20:0] a);
        bit done = 1'b0;
        if (m == 1) begin
            m1_req = 1; m1_cmd_en = 1; m1_cmd = c; m1_addr = a;
            m1_wr_data = wd(a); m1_data_mask = a[7:0];
        end else begin
            m2_req = 1; m2_cmd_en = 1; m2_cmd = c; m2_addr = a;
            m2_wr_data = wd(a); m2_data_mask = a[7:0];
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if ((m == 1 && m1_ready) || (m == 2 && m2_ready)) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        if (m == 1) m1_cmd_en = 0; else m2_cmd_en = 0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL grant_wait m%0d: got no ready in 200 cycles, expected ready", m);
        end
    endtask

    task automatic wait_cmd();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mem_cmd_en) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL cmd_wait: got no mem_cmd_en in 100 cycles, expected one");
        end
    endtask

    // Controller read-return model, called just after a rising edge
    task automatic drive_beats(input int n, input logic [63:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = base + 64'(i);
            @(posedge clk); #1;
            mem_rd_data_valid = 1'b0;
            for (int j = 1; j < gap; j++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Command monitor: grant exclusivity, issued command contents, spacing
    always @(negedge clk) begin
        logic [22:0] e;
        if (m1_ready || m2_ready)
            chk("grant_exclusive", {m1_ready, m2_ready} == 2'b11, 1'b0);
        if (mem_cmd_en) begin
            if (exp_cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_unexpected: got cmd addr %h, expected none", mem_addr);
            end else begin
                e = exp_cmd_q.pop_front();
                chk("cmd_grant", {m2_ready, m1_ready}, e[22] ? 2'b10 : 2'b01);
                chk("cmd_rw", mem_cmd, e[21]);
                chk("cmd_addr", mem_addr, e[20:0]);
                chk("cmd_wdata", mem_wr_data, wd(e[20:0]));
                chk("cmd_mask", mem_data_mask, e[7:0]);
            end
            if (iss_t.size() > 0)
                chk("cmd_min_spacing", (cyc - iss_t[$]) < CMD_GAP, 1'b0);
            iss_t.push_back(cyc);
        end
    end

    // Read-beat monitor: routing, data and hold value of the other master
    always @(negedge clk) begin
        logic [64:0] e;
        if (m1_rd_data_valid || m2_rd_data_valid) begin
            chk("beat_one_hot", m1_rd_data_valid && m2_rd_data_valid, 1'b0);
            if (exp_beat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_unexpected: got valid m1=%b m2=%b, expected none",
                         m1_rd_data_valid, m2_rd_data_valid);
            end else begin
                e = exp_beat_q.pop_front();
                chk("beat_owner", {m2_rd_data_valid, m1_rd_data_valid}, e[64] ? 2'b10 : 2'b01);
                if (e[64]) begin
                    chk("m2_rd_data", m2_rd_data, e[63:0]);
                    chk("m1_rd_hold", m1_rd_data, last_m1);
                    last_m2 = e[63:0];
                end else begin
                    chk("m1_rd_data", m1_rd_data, e[63:0]);
                    chk("m2_rd_hold", m2_rd_data, last_m2);
                    last_m1 = e[63:0];
                end
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit bad, seen;
        resetn = 0; calib = 0;
        m1_req = 0; m2_req = 0; m1_cmd_en = 0; m2_cmd_en = 0; m1_cmd = 0; m2_cmd = 0;
        m1_addr = '0; m2_addr = '0; m1_wr_data = '0; m2_wr_data = '0;
        m1_data_mask = '0; m2_data_mask = '0;
        mem_rd_data = '0; mem_rd_data_valid = 0;
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", {m1_ready, m2_ready, mem_cmd_en, m1_rd_data_valid,
                              m2_rd_data_valid, rd_timeout}, 6'b0);
        resetn = 1;
        @(posedge clk); #1;

        // Calibration gating
        m1_req = 1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (m1_ready || mem_cmd_en) bad = 1;
        end
        chk("calib_low_no_grant", bad, 1'b0);
        @(posedge clk); #1;
        calib = 1;
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge clk);
            if (m1_ready) seen = 1;
        end
        chk("calib_grant_latency", seen, 1'b1);
        @(posedge clk); #1;
        m1_req = 0;
        repeat (3) @(posedge clk); #1;

        // Back-to-back m1 reads
        exp_cmd_q.push_back(ce(1, 0, 21'h000100));
        exp_cmd_q.push_back(ce(1, 0, 21'h000110));
        for (int i = 0; i < 8; i++) exp_beat_q.push_back(be(1, 64'hA000 + 64'(i)));
        fork
            begin
                issue(1, 0, 21'h000100);
                issue(1, 0, 21'h000110);
                m1_req = 0;
            end
            begin
                for (int r = 0; r < 2; r++) begin
                    wait_cmd();
                    @(posedge clk);
                    repeat (3) @(posedge clk);
                    #1;
                    drive_beats(4, 64'hA000 + 64'(r * 4), 1);
                end
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("b2b_spacing", iss_t[$] - iss_t[$-1], 14);
        chk("b2b_beats_drained", exp_beat_q.size(), 0);

        // Starvation guard: four m1 grants, then m2
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(ce(1, 1, 21'h001000 + 21'(i)));
        exp_cmd_q.push_back(ce(2, 1, 21'h002000));
        exp_cmd_q.push_back(ce(1, 1, 21'h001004));
        exp_cmd_q.push_back(ce(1, 1, 21'h001005));
        exp_cmd_q.push_back(ce(2, 1, 21'h002001));
        fork
            begin
                for (int i = 0; i < 6; i++) issue(1, 1, 21'h001000 + 21'(i));
                m1_req = 0;
            end
            begin
                for (int i = 0; i < 2; i++) issue(2, 1, 21'h002000 + 21'(i));
                m2_req = 0;
            end
        join
        repeat (16) @(posedge clk); #1;
        chk("starve_order_drained", exp_cmd_q.size(), 0);

        // Overlapped reads from m1 then m2
        exp_cmd_q.push_back(ce(1, 0, 21'h003000));
        exp_cmd_q.push_back(ce(2, 0, 21'h004000));
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(be(1, 64'hC100 + 64'(i)));
        for (int i = 4; i < 8; i++) exp_beat_q.push_back(be(2, 64'hC100 + 64'(i)));
        fork
            begin issue(1, 0, 21'h003000); m1_req = 0; end
            begin issue(2, 0, 21'h004000); m2_req = 0; end
            begin
                wait_cmd();
                @(posedge clk);
                repeat (11) @(posedge clk);
                #1;
                drive_beats(8, 64'hC100, 2);
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("overlap_beats_drained", exp_beat_q.size(), 0);
        chk("overlap_cmds_drained", exp_cmd_q.size(), 0);
        repeat (12) @(posedge clk); #1;

        // Full owner queue blocks a read grant; head timeout frees it
        exp_cmd_q.push_back(ce(1, 0, 21'h005000));
        exp_cmd_q.push_back(ce(1, 0, 21'h005010));
        exp_cmd_q.push_back(ce(2, 0, 21'h006000));
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(be(1, 64'hD000 + 64'(i)));
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(be(2, 64'hE000 + 64'(i)));
        issue(1, 0, 21'h005000);
        issue(1, 0, 21'h005010);
        m1_req = 0;
        fork
            issue(2, 0, 21'h006000);
            begin
                repeat (16) @(negedge clk);
                chk("full_blocks_ready", m2_ready, 1'b0);
                chk("no_early_timeout", rd_timeout, 1'b0);
            end
        join
        m2_req = 0;
        chk("timeout_release_cycle", iss_t[$] - iss_t[$-2], 33);
        chk("rd_timeout_set", rd_timeout, 1'b1);
        drive_beats(4, 64'hD000, 1);
        drive_beats(4, 64'hE000, 1);
        repeat (3) @(posedge clk); #1;
        chk("timeout_beats_drained", exp_beat_q.size(), 0);
        repeat (10) @(posedge clk); #1;

        // Asynchronous reset with a read outstanding
        exp_cmd_q.push_back(ce(1, 0, 21'h007000));
        issue(1, 0, 21'h007000);
        m1_req = 0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 0;
        mem_rd_data_valid = 1; mem_rd_data = 64'hBAD0;
        #1;
        chk("async_reset_outputs", {m1_ready, m2_ready, mem_cmd_en, m1_rd_data_valid,
                                    m2_rd_data_valid, rd_timeout}, 6'b0);
        iss_t.delete();
        last_m1 = '0; last_m2 = '0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (m1_rd_data_valid || m2_rd_data_valid) bad = 1;
        end
        @(posedge clk); #1;
        mem_rd_data_valid = 0;
        resetn = 1;
        fork
            drive_beats(4, 64'hBAD8, 1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (m1_rd_data_valid || m2_rd_data_valid) bad = 1;
                end
            end
        join
        chk("late_beats_dropped", bad, 1'b0);
        chk("reset_rd_timeout_clear", rd_timeout, 1'b0);

`ifdef PSRAM_SCHED_STATS_EN
        for (int i = 0; i < 3; i++) exp_cmd_q.push_back(ce(2, 1, 21'h008000 + 21'(i)));
        for (int i = 0; i < 3; i++) issue(2, 1, 21'h008000 + 21'(i));
        m2_req = 0;
        repeat (3) @(posedge clk); #1;
        chk("m2_issue_cnt", m2_issue_cnt, 16'd3);
        chk("m1_issue_cnt", m1_issue_cnt, 16'd0);
`endif

        repeat (4) @(posedge clk); #1;
        chk("final_cmds_drained", exp_cmd_q.size(), 0);
        chk("final_beats_drained", exp_beat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
